// File: rtl/core_pkg.sv
// Shared core types for the load/store path: memory controls, LSU FSM states,
// and the byte-lane helpers used by core_lsu.
package core_pkg;

  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } mem_dir_e;

  // funct3 encoding; the unlisted codes 011/110/111 are treated as word accesses
  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_size_e;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'b00,
    LSU_REQ  = 2'b01,
    LSU_WAIT = 2'b10
  } lsu_state_e;

  function automatic logic size_is_byte(mem_size_e size);
    return (size == MEM_B) || (size == MEM_BU);
  endfunction

  function automatic logic size_is_half(mem_size_e size);
    return (size == MEM_H) || (size == MEM_HU);
  endfunction

  function automatic logic [3:0] mem_strb(mem_size_e size, logic [1:0] a);
    logic [3:0] strb;
    if (size_is_byte(size)) begin
      strb = 4'b0001 << a;
    end else if (size_is_half(size)) begin
      strb = a[1] ? 4'b1100 : 4'b0011;
    end else begin
      strb = 4'b1111;
    end
    return strb;
  endfunction

  function automatic logic [31:0] mem_wdata(mem_size_e size, logic [31:0] w);
    logic [31:0] lanes;
    if (size_is_byte(size)) begin
      lanes = {4{w[7:0]}};
    end else if (size_is_half(size)) begin
      lanes = {2{w[15:0]}};
    end else begin
      lanes = w;
    end
    return lanes;
  endfunction

endpackage

// File: rtl/core_lsu_if.sv
// Core data bus between the LSU (master) and the memory system (slave).
interface core_lsu_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, wdata, wstrb,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, wstrb,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/core_lsu_extract.sv
// Load data lane select and sign/zero extension from a bus read word.
module core_lsu_extract
  import core_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  mem_size_e   size_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign byte_s = word_i[{off_i, 3'b000} +: 8];
  assign half_s = off_i[1] ? word_i[31:16] : word_i[15:0];

  // Extension by access size; reserved sizes pass the word through
  always_comb begin
    case (size_i)
      MEM_B:   data_o = {{24{byte_s[7]}}, byte_s};
      MEM_BU:  data_o = {24'h000000, byte_s};
      MEM_H:   data_o = {{16{half_s[15]}}, half_s};
      MEM_HU:  data_o = {16'h0000, half_s};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/core_lsu.sv
// Load/store unit: one word-aligned bus transaction per request, extended load data out.
// Optional misaligned-access trap enabled by defining CORE_LSU_MISALIGN_EXC_EN.
module core_lsu
  import core_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  mem_dir_e        mem_dir,
  input  mem_size_e       mem_size,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            done,
  output logic [XLEN-1:0] rdata,
  output logic            misalign,
  core_lsu_if.master      bus
);

  lsu_state_e  state_q, state_d;
  mem_dir_e    dir_q, dir_d;
  mem_size_e   size_q, size_d;
  logic [1:0]  off_q, off_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_wstrb_q, bus_wstrb_d;
  logic        done_q, done_d;
  logic [31:0] rdata_q, rdata_d;
  logic        misalign_q, misalign_d;
  logic        misaligned_s;
  logic        finish_s;
  logic [31:0] ext_s;

`ifdef CORE_LSU_MISALIGN_EXC_EN
  assign misaligned_s = (size_is_half(mem_size) && addr[0]) ||
                        (!size_is_byte(mem_size) && !size_is_half(mem_size) && (addr[1:0] != 2'b00));
`else
  assign misaligned_s = 1'b0;
`endif

  core_lsu_extract u_extract (
    .word_i (bus.rdata),
    .off_i  (off_q),
    .size_i (size_q),
    .data_o (ext_s)
  );

  // Next-state and registered-output computation for the IDLE/REQ/WAIT sequence
  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    size_d      = size_q;
    off_d       = off_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_wstrb_d = bus_wstrb_q;
    done_d      = 1'b0;
    misalign_d  = 1'b0;
    rdata_d     = rdata_q;
    finish_s    = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        if (req_valid) begin
          dir_d  = mem_dir;
          size_d = mem_size;
          off_d  = addr[1:0];
          if (misaligned_s) begin
            done_d     = 1'b1;
            misalign_d = 1'b1;
            rdata_d    = 32'h0000_0000;
          end else begin
            bus_req_d   = 1'b1;
            bus_we_d    = (mem_dir == MEM_WRITE);
            bus_addr_d  = {addr[31:2], 2'b00};
            bus_wdata_d = mem_wdata(mem_size, wdata);
            bus_wstrb_d = mem_strb(mem_size, addr[1:0]);
            state_d     = LSU_REQ;
          end
        end else begin
          state_d = LSU_IDLE;
        end
      end
      LSU_REQ: begin
        if (bus.gnt) begin
          bus_req_d = 1'b0;
          // A response in the grant cycle completes the access without visiting WAIT
          if (bus.rvalid) begin
            finish_s = 1'b1;
          end else begin
            state_d = LSU_WAIT;
          end
        end else begin
          bus_req_d = 1'b1;
        end
      end
      LSU_WAIT: begin
        if (bus.rvalid) begin
          finish_s = 1'b1;
        end else begin
          state_d = LSU_WAIT;
        end
      end
      default: begin
        state_d   = LSU_IDLE;
        bus_req_d = 1'b0;
      end
    endcase
    if (finish_s) begin
      state_d = LSU_IDLE;
      done_d  = 1'b1;
      rdata_d = (dir_q == MEM_READ) ? ext_s : 32'h0000_0000;
    end else begin
      done_d = done_d;
    end
  end

  // State and output registers; reset abandons any outstanding bus response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LSU_IDLE;
      dir_q       <= MEM_READ;
      size_q      <= MEM_B;
      off_q       <= 2'b00;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0000_0000;
      bus_wdata_q <= 32'h0000_0000;
      bus_wstrb_q <= 4'b0000;
      done_q      <= 1'b0;
      rdata_q     <= 32'h0000_0000;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      size_q      <= size_d;
      off_q       <= off_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wstrb_q <= bus_wstrb_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      misalign_q  <= misalign_d;
    end
  end

  assign req_ready = (state_q == LSU_IDLE);
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign misalign  = misalign_q;
  assign bus.req   = bus_req_q;
  assign bus.we    = bus_we_q;
  assign bus.addr  = bus_addr_q;
  assign bus.wdata = bus_wdata_q;
  assign bus.wstrb = bus_wstrb_q;

endmodule

// File: tb/tb_core_lsu.sv
// Directed self-checking bench for core_lsu: loads, stores, stalls, reset abort, misalignment.
module tb_core_lsu;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  mem_dir_e    mem_dir;
  mem_size_e   mem_size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        done;
  logic [31:0] rdata;
  logic        misalign;
  int          checks   = 0;
  int          failures = 0;

  core_lsu_if bus ();

  core_lsu #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .mem_dir   (mem_dir),
    .mem_size  (mem_size),
    .addr      (addr),
    .wdata     (wdata),
    .done      (done),
    .rdata     (rdata),
    .misalign  (misalign),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic present(input mem_dir_e d, input mem_size_e s, input logic [31:0] a, input logic [31:0] w);
    req_valid = 1'b1;
    mem_dir   = d;
    mem_size  = s;
    addr      = a;
    wdata     = w;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; mem_dir = MEM_READ; mem_size = MEM_W;
    addr = 32'h0; wdata = 32'h0;
    bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = 32'h0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_req",   {31'd0, bus.req}, 32'd0);
    chk("rst_we",    {31'd0, bus.we}, 32'd0);
    chk("rst_addr",  bus.addr, 32'h0);
    chk("rst_wdata", bus.wdata, 32'h0);
    chk("rst_wstrb", {28'd0, bus.wstrb}, 32'd0);
    chk("rst_done",  {31'd0, done}, 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_mis",   {31'd0, misalign}, 32'd0);
    rst_n = 1'b1;
    tick();

    // LW 0x100, grant then response: done three edges after presentation
    present(MEM_READ, MEM_W, 32'h0000_0100, 32'h0);
    chk("lw_req",   {31'd0, bus.req}, 32'd1);
    chk("lw_addr",  bus.addr, 32'h0000_0100);
    chk("lw_strb",  {28'd0, bus.wstrb}, 32'hF);
    chk("lw_we",    {31'd0, bus.we}, 32'd0);
    chk("lw_ready", {31'd0, req_ready}, 32'd0);
    bus.gnt = 1'b1;
    tick();
    bus.gnt = 1'b0;
    chk("lw_req_drop", {31'd0, bus.req}, 32'd0);
    chk("lw_done_early", {31'd0, done}, 32'd0);
    bus.rvalid = 1'b1; bus.rdata = 32'hDEAD_BEEF;
    tick();
    bus.rvalid = 1'b0;
    chk("lw_done",  {31'd0, done}, 32'd1);
    chk("lw_rdata", rdata, 32'hDEAD_BEEF);
    chk("lw_ready_back", {31'd0, req_ready}, 32'd1);

    // LB 0x103 accepted in the done cycle; grant and response together
    present(MEM_READ, MEM_B, 32'h0000_0103, 32'h0);
    chk("lb_done_pulse", {31'd0, done}, 32'd0);
    chk("lb_req",  {31'd0, bus.req}, 32'd1);
    chk("lb_addr", bus.addr, 32'h0000_0100);
    chk("lb_strb", {28'd0, bus.wstrb}, 32'h8);
    bus.gnt = 1'b1; bus.rvalid = 1'b1; bus.rdata = 32'h80FF_0000;
    tick();
    bus.gnt = 1'b0; bus.rvalid = 1'b0;
    chk("lb_done",  {31'd0, done}, 32'd1);
    chk("lb_rdata", rdata, 32'hFFFF_FF80);

    present(MEM_READ, MEM_BU, 32'h0000_0103, 32'h0);
    bus.gnt = 1'b1; bus.rvalid = 1'b1; bus.rdata = 32'h80FF_0000;
    tick();
    bus.gnt = 1'b0; bus.rvalid = 1'b0;
    chk("lbu_rdata", rdata, 32'h0000_0080);

    // SH 0x202: upper half lanes, replicated store data, rdata cleared
    present(MEM_WRITE, MEM_H, 32'h0000_0202, 32'h1234_ABCD);
    chk("sh_we",    {31'd0, bus.we}, 32'd1);
    chk("sh_addr",  bus.addr, 32'h0000_0200);
    chk("sh_strb",  {28'd0, bus.wstrb}, 32'hC);
    chk("sh_wdata", bus.wdata, 32'hABCD_ABCD);
    bus.gnt = 1'b1;
    tick();
    bus.gnt = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'h5555_5555;
    tick();
    bus.rvalid = 1'b0;
    chk("sh_done",  {31'd0, done}, 32'd1);
    chk("sh_rdata", rdata, 32'h0);

    present(MEM_WRITE, MEM_B, 32'h0000_0101, 32'h0000_00A5);
    chk("sb_strb",  {28'd0, bus.wstrb}, 32'h2);
    chk("sb_wdata", bus.wdata, 32'hA5A5_A5A5);
    bus.gnt = 1'b1; bus.rvalid = 1'b1;
    tick();
    bus.gnt = 1'b0; bus.rvalid = 1'b0;

    present(MEM_READ, MEM_H, 32'h0000_0102, 32'h0);
    chk("lh_strb", {28'd0, bus.wstrb}, 32'hC);
    bus.gnt = 1'b1; bus.rvalid = 1'b1; bus.rdata = 32'h8001_0000;
    tick();
    bus.gnt = 1'b0; bus.rvalid = 1'b0;
    chk("lh_rdata", rdata, 32'hFFFF_8001);

    present(MEM_READ, MEM_HU, 32'h0000_0102, 32'h0);
    bus.gnt = 1'b1; bus.rvalid = 1'b1; bus.rdata = 32'h8001_0000;
    tick();
    bus.gnt = 1'b0; bus.rvalid = 1'b0;
    chk("lhu_rdata", rdata, 32'h0000_8001);

    // Reserved size 011 behaves as a word access
    present(MEM_READ, mem_size_e'(3'b011), 32'h0000_0104, 32'h0);
    chk("rsv_strb", {28'd0, bus.wstrb}, 32'hF);
    bus.gnt = 1'b1; bus.rvalid = 1'b1; bus.rdata = 32'h1234_5678;
    tick();
    bus.gnt = 1'b0; bus.rvalid = 1'b0;
    chk("rsv_rdata", rdata, 32'h1234_5678);

    // Grant withheld five cycles, response three cycles after grant
    present(MEM_READ, MEM_W, 32'h0000_0300, 32'h0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_req",   {31'd0, bus.req}, 32'd1);
      chk("stall_addr",  bus.addr, 32'h0000_0300);
      chk("stall_strb",  {28'd0, bus.wstrb}, 32'hF);
      chk("stall_ready", {31'd0, req_ready}, 32'd0);
      chk("stall_done",  {31'd0, done}, 32'd0);
      tick();
    end
    bus.gnt = 1'b1;
    tick();
    bus.gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("wait_req",   {31'd0, bus.req}, 32'd0);
      chk("wait_ready", {31'd0, req_ready}, 32'd0);
      chk("wait_done",  {31'd0, done}, 32'd0);
      tick();
    end
    bus.rvalid = 1'b1; bus.rdata = 32'hCAFE_F00D;
    tick();
    bus.rvalid = 1'b0;
    chk("stall_done_hi", {31'd0, done}, 32'd1);
    chk("stall_rdata", rdata, 32'hCAFE_F00D);
    tick();
    chk("stall_done_once", {31'd0, done}, 32'd0);

    // Stray response while idle is ignored
    bus.rvalid = 1'b1;
    tick();
    bus.rvalid = 1'b0;
    chk("idle_rvalid_done",  {31'd0, done}, 32'd0);
    chk("idle_rvalid_ready", {31'd0, req_ready}, 32'd1);

    // Reset while in WAIT, then a late response
    present(MEM_READ, MEM_W, 32'h0000_0400, 32'h0);
    bus.gnt = 1'b1;
    tick();
    bus.gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_req",   {31'd0, bus.req}, 32'd0);
    chk("abort_addr",  bus.addr, 32'h0);
    chk("abort_strb",  {28'd0, bus.wstrb}, 32'd0);
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_rdata", rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.rvalid = 1'b1; bus.rdata = 32'h1111_1111;
    tick();
    bus.rvalid = 1'b0;
    chk("late_rvalid_done",  {31'd0, done}, 32'd0);
    chk("late_rvalid_rdata", rdata, 32'h0);
    tick();
    chk("late_rvalid_done2", {31'd0, done}, 32'd0);

    // Misaligned word load
    present(MEM_READ, MEM_W, 32'h0000_0101, 32'h0);
`ifdef CORE_LSU_MISALIGN_EXC_EN
    chk("mis_req",   {31'd0, bus.req}, 32'd0);
    chk("mis_done",  {31'd0, done}, 32'd1);
    chk("mis_flag",  {31'd0, misalign}, 32'd1);
    chk("mis_rdata", rdata, 32'h0);
    chk("mis_ready", {31'd0, req_ready}, 32'd1);
    tick();
    chk("mis_done_once", {31'd0, done}, 32'd0);
`else
    chk("unal_req",  {31'd0, bus.req}, 32'd1);
    chk("unal_addr", bus.addr, 32'h0000_0100);
    chk("unal_strb", {28'd0, bus.wstrb}, 32'hF);
    chk("unal_mis",  {31'd0, misalign}, 32'd0);
    bus.gnt = 1'b1; bus.rvalid = 1'b1; bus.rdata = 32'h0102_0304;
    tick();
    bus.gnt = 1'b0; bus.rvalid = 1'b0;
    chk("unal_done",  {31'd0, done}, 32'd1);
    chk("unal_rdata", rdata, 32'h0102_0304);
    chk("unal_mis2",  {31'd0, misalign}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
